// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared mode encodings and decode helpers for dec_scan_nx.
package dec_scan_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int num_out(input int sel_w);
    return 1 << sel_w;
  endfunction
  // Out-of-range indices decode to all zeros rather than aliasing.
  function automatic logic [63:0] onehot(input int index, input int width);
    return (index < width) ? 64'(1) << index : '0;
  endfunction
endpackage

// File: rtl/dec_dwell_timer.sv
// dec_dwell_timer: counts 0..DWELL-1 while run is high and pulses tc on the terminal count.
module dec_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tc
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tc = run && cnt_q == CW'(DWELL - 1);
    cnt_d = clear ? '0 : !run ? cnt_q : tc ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dec_scan_nx.sv
// dec_scan_nx: registered N-to-2^N one-hot decoder with direct select and timed scan modes.
// Define DEC_SCAN_ACTIVE_LOW_EN to drive D inverted (one bit low, idle all ones).
module dec_scan_nx
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      sel_valid,
  input  logic [SEL_W-1:0]          sel,
  output logic [num_out(SEL_W)-1:0] D,
  output logic [SEL_W-1:0]          idx,
  output logic                      step,
  output logic                      wrap
);
  localparam int NOUT = num_out(SEL_W);
`ifdef DEC_SCAN_ACTIVE_LOW_EN
  localparam logic [NOUT-1:0] OFF = '1;
`else
  localparam logic [NOUT-1:0] OFF = '0;
`endif
  logic tc, load, adv, step_d, wrap_d, step_q, wrap_q;
  logic [SEL_W-1:0] idx_d, idx_q;
  logic [NOUT-1:0] d_d, d_q;
  // Direct mode keeps the timer cleared so a later switch to scan dwells a full period first.
  dec_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (en && mode == MODE_SCAN),
    .clear (en && mode == MODE_DIRECT),
    .tc    (tc)
  );
  always_comb begin
    load = en && mode == MODE_DIRECT && sel_valid;
    adv = en && mode == MODE_SCAN && tc;
    idx_d = load ? sel : adv ? idx_q + 1'b1 : idx_q;
    step_d = load || adv;
    wrap_d = adv && idx_q == '1;
    d_d = en ? NOUT'(onehot(int'(idx_d), NOUT)) ^ OFF : OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      d_q <= OFF;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      d_q <= d_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  assign D = d_q;
  assign idx = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_dec_scan_nx.sv
// tb_dec_scan_nx: directed self-checking bench for dec_scan_nx (2-bit/DWELL 4 and 3-bit/DWELL 1 instances).
module tb_dec_scan_nx;
  logic clk = 1'b0, rst = 1'b1;
  logic en = 1'b0, mode = 1'b0, sv = 1'b0;
  logic [1:0] sel = '0, idx;
  logic [3:0] d;
  logic step, wrap;
  logic b_en = 1'b0, b_mode = 1'b0, b_sv = 1'b0;
  logic [2:0] b_sel = '0, b_idx;
  logic [7:0] b_d;
  logic b_step, b_wrap;
  int checks = 0, errors = 0;
`ifdef DEC_SCAN_ACTIVE_LOW_EN
  logic [3:0] pa = 4'hF;
  logic [7:0] pb = 8'hFF;
`else
  logic [3:0] pa = 4'h0;
  logic [7:0] pb = 8'h00;
`endif

  always #5 clk = ~clk;

  dec_scan_nx #(.SEL_W(2), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sv), .sel(sel),
    .D(d), .idx(idx), .step(step), .wrap(wrap));
  dec_scan_nx #(.SEL_W(3), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sel_valid(b_sv), .sel(b_sel),
    .D(b_d), .idx(b_idx), .step(b_step), .wrap(b_wrap));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] ed, input int ei, input logic es, input logic ew);
    chk({tag, ".D"}, 64'(d), 64'(ed ^ pa));
    chk({tag, ".idx"}, 64'(idx), 64'(ei));
    chk({tag, ".step"}, 64'(step), 64'(es));
    chk({tag, ".wrap"}, 64'(wrap), 64'(ew));
  endtask

  initial begin
    tick;
    chk("rst.a.D", 64'(d), 64'(pa));
    chk("rst.a.idx", 64'(idx), 64'd0);
    chk("rst.a.step", 64'(step), 64'd0);
    chk("rst.b.D", 64'(b_d), 64'(pb));
    rst = 1'b0;
    // direct decode, one cycle latency
    en = 1'b1; sv = 1'b1;
    sel = 2'd0; tick; chk_a("dir0", 4'b0001, 0, 1, 0);
    sel = 2'd1; tick; chk_a("dir1", 4'b0010, 1, 1, 0);
    sel = 2'd2; tick; chk_a("dir2", 4'b0100, 2, 1, 0);
    sel = 2'd3; tick; chk_a("dir3", 4'b1000, 3, 1, 0);
    sv = 1'b0; tick; chk_a("dir_hold", 4'b1000, 3, 0, 0);
    sv = 1'b1; tick; chk_a("dir_repeat", 4'b1000, 3, 1, 0);
    sel = 2'd0; tick; chk_a("dir_back0", 4'b0001, 0, 1, 0);
    sv = 1'b0;
    // scan: four edges per output, wrap on the 3->0 step
    mode = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk_a($sformatf("scan%0d", k), 4'(1 << ((k / 4) % 4)), (k / 4) % 4, k % 4 == 0, k == 16);
    end
    // reach idx 2 with dwell count 1, then gate
    repeat (9) tick;
    chk_a("pre_gate", 4'b0100, 2, 0, 0);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_a("gated", 4'b0000, 2, 0, 0);
    end
    en = 1'b1;
    tick; chk_a("ungate1", 4'b0100, 2, 0, 0);
    tick; chk_a("ungate2", 4'b0100, 2, 0, 0);
    tick; chk_a("ungate3", 4'b1000, 3, 1, 0);
    // mode handover: sel_valid on the edge mode rises is discarded
    mode = 1'b0; sv = 1'b1; sel = 2'd3;
    tick; chk_a("hand_dir", 4'b1000, 3, 1, 0);
    mode = 1'b1; sel = 2'd1;
    tick; chk_a("hand_edge", 4'b1000, 3, 0, 0);
    sv = 1'b0;
    tick; chk_a("hand_h2", 4'b1000, 3, 0, 0);
    tick; chk_a("hand_h3", 4'b1000, 3, 0, 0);
    tick; chk_a("hand_wrap", 4'b0001, 0, 1, 1);
    // asynchronous reset between edges while scanning at idx 2
    repeat (8) tick;
    chk_a("pre_rst", 4'b0100, 2, 1, 0);
    #2 rst = 1'b1;
    #1 chk_a("async_rst", 4'b0000, 0, 0, 0);
    tick; chk_a("rst_held", 4'b0000, 0, 0, 0);
    rst = 1'b0;
    tick; chk_a("post_rst", 4'b0001, 0, 0, 0);
    tick; chk_a("pre_clr", 4'b0001, 0, 0, 0);
    // scan->direct clears the dwell counter
    mode = 1'b0;
    tick; chk_a("clr_dir", 4'b0001, 0, 0, 0);
    mode = 1'b1;
    repeat (3) tick;
    chk_a("clr_dwell3", 4'b0001, 0, 0, 0);
    tick; chk_a("clr_adv", 4'b0010, 1, 1, 0);
    // 3-bit, DWELL 1: advances every edge
    b_en = 1'b1; b_sv = 1'b1; b_sel = 3'd0;
    tick;
    chk("b_load.D", 64'(b_d), 64'(8'h01 ^ pb));
    chk("b_load.idx", 64'(b_idx), 64'd0);
    b_mode = 1'b1; b_sv = 1'b0; b_sel = 3'd5;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk($sformatf("b_scan%0d.D", k), 64'(b_d), 64'(8'(1 << (k % 8)) ^ pb));
      chk($sformatf("b_scan%0d.idx", k), 64'(b_idx), 64'(k % 8));
      chk($sformatf("b_scan%0d.step", k), 64'(b_step), 64'd1);
      chk($sformatf("b_scan%0d.wrap", k), 64'(b_wrap), 64'(k == 8));
    end
    b_en = 1'b0;
    tick;
    chk("b_off.D", 64'(b_d), 64'(pb));
    chk("b_off.step", 64'(b_step), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_scan_nx.md
Name: dec_scan_nx

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 2x4 combinational decoder.
- Two modes:
  - Direct: decodes an externally supplied select.
  - Scan: steps an internal index through all outputs with a programmable dwell time.
- Used for digit/row select in multiplexed displays and for bus-slave enables.
- Sits between control logic and the output drivers.

Parameters:
- SEL_W, 2, select width; outputs = 2^SEL_W; legal 1..6.
- DWELL, 4, clock cycles each output stays active in scan mode; legal >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  decoder enable; 0 forces all outputs inactive.
- mode  in  1  0 = direct, 1 = scan.
- sel_valid  in  1  qualifies sel in direct mode.
- sel  in  SEL_W  select value in direct mode.
- D  out  2^SEL_W  registered one-hot output.
- idx  out  SEL_W  current decoded index (registered).
- step  out  1  one-cycle pulse when idx is updated.
- wrap  out  1  one-cycle pulse when scan index rolls from 2^SEL_W-1 to 0.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - D = 0, idx = 0, step = 0, wrap = 0.
  - Dwell counter = 0.
  - First active output after reset release requires en = 1 and one clock edge.
- Registered output rule at every edge:
  - When en = 1: D <= 1 << idx_next.
  - When en = 0: D <= 0.
- D always has exactly one bit set, or none.
- en = 0:
  - idx, dwell counter and mode state hold.
  - step = wrap = 0.
  - sel_valid is ignored.
- Direct mode (mode = 0, en = 1):
  - sel_valid = 1: idx <= sel, D <= 1 << sel, step = 1. Latency is 1 cycle from sel_valid to D.
  - sel_valid = 0: idx and D hold, step = 0.
  - Repeating the same sel still pulses step.
  - Dwell counter is held at 0.
- Scan mode (mode = 1, en = 1):
  - Dwell counter counts 0..DWELL-1.
  - At terminal count:
    - Counter returns to 0.
    - idx <= idx + 1, modulo 2^SEL_W.
    - step = 1.
    - wrap = 1 only when the old idx is 2^SEL_W-1.
  - Each output is active for exactly DWELL cycles.
  - DWELL = 1 advances every cycle.
  - sel and sel_valid are ignored.
- Mode switching:
  - Direct -> scan: scan starts from the current idx. Dwell counter is cleared, so the first advance comes DWELL cycles after mode rises.
  - Scan -> direct: dwell counter is cleared. idx holds until the next sel_valid.
  - mode, sel_valid and en are sampled on the same edge. A sel_valid pulse on the edge where mode = 1 is discarded.
- SEL_W = 1 degenerates to a 1:2 decoder. The scan toggles between the two outputs; wrap pulses on every second step.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DEC_SCAN_ACTIVE_LOW_EN.
- Defined: D is driven inverted, one bit low and the rest high. Reset and en = 0 drive D to all ones. idx, step and wrap are unchanged.
- Undefined: D is active-high as described above.

Decomposition:
- Package dec_scan_pkg:
  - Constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - Function onehot(index, width).
  - Localparam-style helper for the output count 2^SEL_W.
- Sub-module dec_dwell_timer (parameter DWELL):
  - Inputs: clk, rst, run, clear.
  - Output: tc, the terminal-count pulse.
  - Dwell counter width is clog2(DWELL), minimum 1.
- The top level holds the idx/D registers and the mode logic.

Test Plan (SEL_W = 2, DWELL = 4 unless stated):
1. Reset then direct decode:
   - Stimulus: rst pulse; en = 1, mode = 0; sel_valid with sel = 0, 1, 2, 3 on consecutive cycles.
   - Response: D = 0001, 0010, 0100, 1000, each one cycle after its sel; step high on each of the four cycles.
2. Scan dwell and wrap:
   - Stimulus: en = 1, mode = 1 from idx = 0.
   - Response: D = 0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each, then 0001 again; wrap pulses exactly once, on the 3 -> 0 step; step pulses every 4 cycles.
3. Enable gating:
   - Stimulus: drop en for 3 cycles mid-scan at idx = 2, dwell count 1; then restore en.
   - Response: D = 0000 during the 3 cycles; idx stays 2; after en returns, D = 0100 and the remaining dwell is 2 more cycles before idx = 3.
4. Mode handover:
   - Stimulus: in direct mode, sel = 3 accepted; set mode = 1 on the same edge as sel_valid with sel = 1.
   - Response: sel = 1 is ignored; scan continues from idx = 3; wrap to idx = 0 occurs 4 cycles after mode rises.
5. Asynchronous reset mid-operation:
   - Stimulus: assert rst between clock edges during scan at idx = 2.
   - Response: D = 0000 and idx = 0 immediately, with no clock edge needed; step = wrap = 0.
6. Parameter sweep and polarity:
   - Stimulus: SEL_W = 3, DWELL = 1 in scan mode; repeat the run with DEC_SCAN_ACTIVE_LOW_EN defined.
   - Response: D walks through 8 one-hot values in 8 cycles with wrap every 8 cycles; with the macro defined, every value is inverted (e.g. 11111110 first) and reset gives 11111111.
